// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and the requester-sharing arbiter:
// width constants, opcode encodings, FSM state enum, operation payload and
// a one-hot helper for requester indices.
package alu_pkg;

  localparam int unsigned ALU_W   = 4;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned MAX_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
  localparam logic [OP_W-1:0] OP_NAND = 3'b001;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
  localparam logic [OP_W-1:0] OP_INC  = 3'b110;
  localparam logic [OP_W-1:0] OP_DEC  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Captured operation payload
  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_op_t;

  // One-hot over the maximum requester count
  function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU with signed-overflow status.
// Ports: opcode_i (3b), a_i/b_i (4b operands) -> result_o (4b), status_o (overflow).
module alu4_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  opcode_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  output logic [ALU_W-1:0] result_o,
  output logic             status_o
);

  logic [ALU_W-1:0] res_c;
  logic             ovf_c;

  // Result and overflow; arithmetic wraps modulo 2^ALU_W
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    unique case (opcode_i)
      OP_NOT:  res_c = ~a_i;
      OP_NAND: res_c = ~(a_i & b_i);
      OP_NOR:  res_c = ~(a_i | b_i);
      OP_XOR:  res_c = a_i ^ b_i;
      OP_ADD: begin
        res_c = a_i + b_i;
        ovf_c = (a_i[ALU_W-1] == b_i[ALU_W-1]) && (res_c[ALU_W-1] != a_i[ALU_W-1]);
      end
      OP_SUB: begin
        res_c = a_i - b_i;
        ovf_c = (a_i[ALU_W-1] != b_i[ALU_W-1]) && (res_c[ALU_W-1] != a_i[ALU_W-1]);
      end
      OP_INC: begin
        res_c = b_i + ALU_W'(1);
        ovf_c = (b_i == ALU_W'(7));
      end
      OP_DEC: begin
        res_c = b_i - ALU_W'(1);
        ovf_c = (b_i == ALU_W'(8));
      end
      default: begin
        res_c = '0;
        ovf_c = 1'b0;
      end
    endcase
  end

  assign result_o = res_c;
  assign status_o = ovf_c;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one alu4_core between NUM_REQ requesters with
// valid/ready handshakes on request and response, plus a saturating
// overflow-event counter.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready (one-hot accept),
// req_opcode/req_a/req_b (packed per requester); rsp_valid (one-hot owner),
// rsp_ready, rsp_result, rsp_status; ovf_count, ovf_clear.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned OVF_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_opcode,
  input  logic [ALU_W*NUM_REQ-1:0]  req_a,
  input  logic [ALU_W*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [ALU_W-1:0]          rsp_result,
  output logic                      rsp_status,
  output logic [OVF_CNT_W-1:0]      ovf_count,
  input  logic                      ovf_clear
);

  state_e               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     gnt_q;
  alu_op_t              op_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [ALU_W-1:0]     rsp_result_q;
  logic                 rsp_status_q;
  logic [OVF_CNT_W-1:0] ovf_count_q;

  logic [MAX_REQ-1:0]   req_valid_ext;
  logic [MAX_REQ-1:0]   rsp_ready_ext;
  logic                 gnt_found;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     cand;
  alu_op_t              sel_op;
  logic [ALU_W-1:0]     alu_res;
  logic                 alu_ovf;

  // Widen to MAX_REQ so a 2-bit index always selects cleanly
  assign req_valid_ext = MAX_REQ'(req_valid);
  assign rsp_ready_ext = MAX_REQ'(rsp_ready);

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
      if (!gnt_found && req_valid_ext[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Acceptance is only offered while idle
  assign req_ready = (state_q == ST_IDLE && gnt_found) ?
                     NUM_REQ'(idx_onehot(gnt_idx)) : '0;

  // Operand mux for the granted requester
  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_op.opcode = req_opcode[OP_W*i +: OP_W];
        sel_op.a      = req_a[ALU_W*i +: ALU_W];
        sel_op.b      = req_b[ALU_W*i +: ALU_W];
      end
    end
  end

  alu4_core u_alu (
    .opcode_i (op_q.opcode),
    .a_i      (op_q.a),
    .b_i      (op_q.b),
    .result_o (alu_res),
    .status_o (alu_ovf)
  );

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      op_q         <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_status_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_found) begin
            op_q    <= sel_op;
            gnt_q   <= gnt_idx;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q <= alu_res;
          rsp_status_q <= alu_ovf;
          rsp_valid_q  <= NUM_REQ'(idx_onehot(gnt_q));
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owning requester's ready completes the response
          if (rsp_ready_ext[gnt_q]) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= IDX_W'((32'(gnt_q) + 32'd1) % NUM_REQ);
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Overflow event counter; clear beats a coincident increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count_q <= '0;
    end else if (ovf_clear) begin
      ovf_count_q <= '0;
    end else if (state_q == ST_EXEC && alu_ovf && ovf_count_q != '1) begin
      ovf_count_q <= ovf_count_q + OVF_CNT_W'(1);
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_status = rsp_status_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scoreboard bench for alu_share_arbiter (NUM_REQ=2, OVF_CNT_W=2).
module tb_alu_share_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [3*NR-1:0] req_opcode;
  logic [4*NR-1:0] req_a;
  logic [4*NR-1:0] req_b;
  logic [NR-1:0] rsp_valid;
  logic [NR-1:0] rsp_ready;
  logic [3:0]    rsp_result;
  logic          rsp_status;
  logic [CW-1:0] ovf_count;
  logic          ovf_clear;

  typedef struct {
    int         idx;
    logic [3:0] res;
    logic       st;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_ovf = 0;

  alu_share_arbiter #(.NUM_REQ(NR), .OVF_CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_status (rsp_status),
    .ovf_count  (ovf_count),
    .ovf_clear  (ovf_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU using signed integer range checks for overflow
  function automatic void alu_model(input logic [2:0] op, input logic [3:0] a,
                                    input logic [3:0] b, output logic [3:0] r,
                                    output logic s);
    int sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = 1'b0;
    case (op)
      3'd0: r = ~a;
      3'd1: r = ~(a & b);
      3'd2: r = ~(a | b);
      3'd3: r = a ^ b;
      3'd4: begin sr = sa + sb; r = a + b;    s = (sr > 7) || (sr < -8); end
      3'd5: begin sr = sa - sb; r = a - b;    s = (sr > 7) || (sr < -8); end
      3'd6: begin sr = sb + 1;  r = b + 4'd1; s = (sr > 7); end
      default: begin sr = sb - 1; r = b - 4'd1; s = (sr < -8); end
    endcase
  endfunction

  function automatic void ovf_step(input logic st, input bit clr);
    if (clr) model_ovf = 0;
    else if (st && model_ovf < (1 << CW) - 1) model_ovf++;
  endfunction

  // One operation from requester idx, optional response backpressure,
  // optional competing request during RESP, optional clear during EXEC
  task automatic do_op(input int idx, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input int hold, input bit other_valid,
                       input bit clr_in_exec);
    exp_t e;
    int   n;
    req_opcode[3*idx +: 3] = op;
    req_a[4*idx +: 4] = a;
    req_b[4*idx +: 4] = b;
    req_valid[idx] = 1'b1;
    #1;
    n = 0;
    while (req_ready[idx] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_wait", 32'(n < 20), 32'd1);
    chk("req_ready_onehot", 32'(req_ready), 32'(2'b01 << idx));
    e.idx = idx;
    e.cyc = 0;
    alu_model(op, a, b, e.res, e.st);
    sb_q.push_back(e);
    tick();
    req_valid[idx] = 1'b0;
    if (clr_in_exec) ovf_clear = 1'b1;
    chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    ovf_clear = 1'b0;
    chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      ovf_step(e.st, clr_in_exec);
      chk("rsp_valid_owner", 32'(rsp_valid), 32'(2'b01 << e.idx));
      chk("rsp_result", 32'(rsp_result), 32'(e.res));
      chk("rsp_status", 32'(rsp_status), 32'(e.st));
      chk("ovf_count", 32'(ovf_count), 32'(model_ovf));
    end
    if (other_valid) begin
      req_valid[1-idx] = 1'b1;
      #1;
    end
    for (int h = 0; h < hold; h++) begin
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(2'b01 << idx));
      chk("bp_result", 32'(rsp_result), 32'(e.res));
      chk("bp_status", 32'(rsp_status), 32'(e.st));
      tick();
    end
    if (other_valid) req_valid[1-idx] = 1'b0;
    rsp_ready[idx] = 1'b1;
    #1;
    tick();
    rsp_ready = '0;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("idle_no_grant", 32'(req_ready), 32'd0);
  endtask

  logic [2:0] c_op[2];
  logic [3:0] c_a[2];
  logic [3:0] c_b[2];
  int gl[4];
  int gc[4];
  int gcnt, rcnt, g;
  exp_t ce;

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_opcode = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '0;
    ovf_clear = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);

    // Single request: ADD 0111+0001 -> 1000, overflow
    do_op(0, 3'b100, 4'b0111, 4'b0001, 0, 1'b0, 1'b0);
    chk("single_ovf_count", 32'(ovf_count), 32'd1);

    // Opcode sweep
    for (int op = 0; op < 8; op++)
      do_op(0, 3'(op), 4'b1010, 4'b0110, 0, 1'b0, 1'b0);

    // Saturation then clear-over-increment
    for (int k = 0; k < 5; k++)
      do_op(0, 3'b100, 4'b0111, 4'b0001, 0, 1'b0, 1'b0);
    chk("ovf_saturated", 32'(ovf_count), 32'd3);
    do_op(0, 3'b100, 4'b0111, 4'b0001, 0, 1'b0, 1'b1);
    chk("ovf_clear_wins", 32'(ovf_count), 32'd0);

    // Backpressure on requester 1 with requester 0 competing
    do_op(1, 3'b011, 4'b1010, 4'b0110, 5, 1'b1, 1'b0);

    // Reset mid-EXEC: move rr_ptr to 1, then abort an overflowing op
    do_op(0, 3'b011, 4'b0001, 4'b0010, 0, 1'b0, 1'b0);
    req_opcode[5:3] = 3'b100;
    req_a[7:4] = 4'b0111;
    req_b[7:4] = 4'b0001;
    req_valid = 2'b10;
    #1;
    chk("mid_grant1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_ovf = 0;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_ovf_count", 32'(ovf_count), 32'd0);
    tick();
    chk("mid_rsp_valid2", 32'(rsp_valid), 32'd0);
    chk("mid_ovf_count2", 32'(ovf_count), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("mid_rr_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    #1;
    chk("drop_no_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    chk("drop_no_rsp", 32'(rsp_valid), 32'd0);

    // Contention from reset: alternating grants, 3-cycle issue interval
    c_op[0] = 3'b100; c_a[0] = 4'b0011; c_b[0] = 4'b0001;
    c_op[1] = 3'b101; c_a[1] = 4'b1000; c_b[1] = 4'b0001;
    req_opcode = {c_op[1], c_op[0]};
    req_a = {c_a[1], c_a[0]};
    req_b = {c_b[1], c_b[0]};
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    model_ovf = 0;
    gcnt = 0;
    rcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_ready != '0) begin
        g = req_ready[1] ? 1 : 0;
        if (gcnt < 4) begin
          gl[gcnt] = g;
          gc[gcnt] = c;
        end
        gcnt++;
        ce.idx = g;
        ce.cyc = c;
        alu_model(c_op[g], c_a[g], c_b[g], ce.res, ce.st);
        sb_q.push_back(ce);
      end
      if (rsp_valid != '0) begin
        chk("con_sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          ce = sb_q.pop_front();
          ovf_step(ce.st, 1'b0);
          chk("con_rsp_owner", 32'(rsp_valid), 32'(2'b01 << ce.idx));
          chk("con_rsp_result", 32'(rsp_result), 32'(ce.res));
          chk("con_rsp_status", 32'(rsp_status), 32'(ce.st));
          chk("con_rsp_latency", 32'(c), 32'(ce.cyc + 2));
          chk("con_ovf_count", 32'(ovf_count), 32'(model_ovf));
        end
        rcnt++;
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;
    chk("con_grants", 32'(gcnt), 32'd4);
    chk("con_rsps", 32'(rcnt), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gcnt) begin
        chk("con_grant_order", 32'(gl[k]), 32'(k % 2));
        chk("con_grant_cycle", 32'(gc[k]), 32'(3 * k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 4-bit ALU core between up to four requesters using round-robin arbitration with valid/ready handshakes on both the request and response sides. Each granted operation is captured, executed on the ALU, and returned with its signed-overflow status to the requester that issued it. The block also keeps a saturating count of overflow events for the status/debug register file. It sits between the operand-issuing control units and the ALU core.

## Interface
- NUM_REQ, 2 — number of requesters, legal range 2..4
- OVF_CNT_W, 8 — width of the overflow event counter
- clk  in  1  — single clock, all state updates on the rising edge
- rst_n  in  1  — synchronous, active-low reset
- req_valid  in  NUM_REQ  — per-requester operation request
- req_ready  out  NUM_REQ  — one-hot acceptance; at most one bit high
- req_opcode  in  3*NUM_REQ  — requester i occupies bits [3i+2:3i]
- req_a  in  4*NUM_REQ  — operand A, requester i occupies bits [4i+3:4i]
- req_b  in  4*NUM_REQ  — operand B, same packing as req_a
- rsp_valid  out  NUM_REQ  — one-hot result-valid to the owning requester
- rsp_ready  in  NUM_REQ  — per-requester result acceptance
- rsp_result  out  4  — ALU result, valid while any rsp_valid bit is high
- rsp_status  out  1  — signed-overflow flag for rsp_result
- ovf_count  out  OVF_CNT_W  — saturating count of completed ops with status=1
- ovf_clear  in  1  — synchronous clear of ovf_count

## Operation
- FSM states: IDLE, EXEC, RESP. Reset: IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_status=0, ovf_count=0.
- IDLE: if any req_valid is set, the grant goes to the first set bit at or after rr_ptr, wrapping modulo NUM_REQ. req_ready[grant] is high combinationally in that cycle. Opcode, A, B and the grant index are captured, then the FSM moves to EXEC. With no req_valid set, the FSM stays in IDLE.
- EXEC: the ALU core evaluates the captured operands. Result and status are registered, then the FSM moves to RESP.
- RESP: rsp_valid[grant]=1, with result and status held stable. On rsp_ready[grant]=1: rsp_valid drops, rr_ptr=(grant+1) mod NUM_REQ, and the FSM returns to IDLE. rsp_ready bits of other requesters are ignored.
- Opcodes: 000 ~A; 001 ~(A&B); 010 ~(A|B); 011 A^B; 100 A+B; 101 A−B; 110 B+1; 111 B−1. All arithmetic is modulo 16.
- Status rules:
  - Logic ops (000–011): status=0.
  - ADD: 1 iff A[3]==B[3] and R[3]!=A[3].
  - SUB: 1 iff A[3]!=B[3] and R[3]!=A[3].
  - INC: 1 iff B==4'b0111.
  - DEC: 1 iff B==4'b1000.
- ovf_count increments on the EXEC→RESP transition when status=1 and saturates at all-ones. If ovf_clear coincides with an increment, clear wins and the result is 0.
- Requesters must hold valid and operands until ready. Dropping valid before a grant is legal and has no effect.
- Reset asserted mid-operation aborts the operation. No response is produced, and the state returns to reset values on the next edge.

## Timing
- Accept at edge T (req_ready high in cycle T−1 to T). rsp_valid is high from cycle T+2.
- Minimum issue interval: 3 cycles per operation, when rsp_ready is held high.
- No combinational path from req_* to rsp_*. req_ready depends only on req_valid, rr_ptr and state.
- Backpressure: RESP holds indefinitely. No new grant is issued until the response is accepted.

## Structure
- Shared package alu_pkg holds:
  - the opcode localparams (OP_NOT … OP_DEC)
  - the FSM state enum
  - the width constants (ALU_W=4, OP_W=3)
- Sub-module alu4_core: purely combinational, with opcode/A/B in and result/status out, implementing the rules above. It is reusable by other blocks.
- Round-robin grant logic stays inline in alu_share_arbiter.

## Test plan
- Single request: requester 0 issues ADD A=0111, B=0001 → rsp_valid[0] two cycles after accept, result=1000, status=1, ovf_count=1.
- Contention: both requesters continuously valid from reset → grants alternate 0,1,0,1. Requester 1 issues SUB 1000−0001 → result=0111, status=1.
- Backpressure: hold rsp_ready[1]=0 for 5 cycles in RESP → result and status are stable, req_ready stays 0 for all requesters, and the FSM exits one cycle after rsp_ready[1]=1.
- Opcode sweep: A=1010, B=0110 across all eight opcodes → 0101, 1101, 0001, 1100, 0000/status 0, 0100/status 1, 0111/status 0, 0101/status 0.
- Counter: OVF_CNT_W=2, force 5 overflowing ops → count reaches 3 and stays there. Assert ovf_clear together with an overflowing op → count=0.
- Reset mid-EXEC: rst_n=0 for one cycle → no rsp_valid, ovf_count=0, rr_ptr=0, and the next grant goes to requester 0.
